// File: rtl/rv32i_multicycle_core_if.sv
// rtl/rv32i_multicycle_core_if.sv - shared instruction/data memory port of the multicycle core
interface rv32i_multicycle_core_if;
   logic [31:0] memReadData;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;

   modport master (
      input  memReadData,
      output memAddress,
      output memWriteData,
      output memWrite
   );

   modport slave (
      output memReadData,
      input  memAddress,
      input  memWriteData,
      input  memWrite
   );
endinterface

// File: rtl/rv32i_multicycle_core.sv
// rtl/rv32i_multicycle_core.sv - multicycle non-pipelined RV32I core, one shared memory port
module rv32i_multicycle_core (
   input  logic                           clk,
   input  logic                           reset,
   rv32i_multicycle_core_if.master        bus
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTE,
      S_ALUWB,
      S_BRANCH,
      S_JUMP
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_old_pc;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;
   logic [31:0] r_rf [0:31];

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic [31:0] w_alu_b;
   logic        w_alu_alt;
   logic [31:0] w_alu_y;
   logic [31:0] w_exec_y;
   logic        w_branch_taken;
   logic        w_rf_we;
   logic [31:0] w_rf_wdata;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_funct3 = r_ir[14:12];
   assign w_rs1    = r_ir[19:15];
   assign w_rs2    = r_ir[24:20];

   assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
   assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
   assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
   assign w_imm_u = {r_ir[31:12], 12'd0};
   assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

   // x0 is forced to zero on the read side so a stray write could never leak out
   assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

   assign bus.memWriteData = r_b;

   // funct7[5] selects SUB/SRA for register ops, but only SRAI among the immediate ops
   always_comb begin
      w_alu_b   = w_imm_i;
      w_alu_alt = r_ir[30] && (w_funct3 == 3'b101);
      if (w_opcode == OPC_OP) begin
         w_alu_b   = r_b;
         w_alu_alt = r_ir[30];
      end
      case (w_funct3)
         3'b000:  w_alu_y = w_alu_alt ? (r_a - w_alu_b) : (r_a + w_alu_b);
         3'b001:  w_alu_y = r_a << w_alu_b[4:0];
         3'b010:  w_alu_y = {31'd0, $signed(r_a) < $signed(w_alu_b)};
         3'b011:  w_alu_y = {31'd0, r_a < w_alu_b};
         3'b100:  w_alu_y = r_a ^ w_alu_b;
         3'b101:  w_alu_y = w_alu_alt ? $unsigned($signed(r_a) >>> w_alu_b[4:0])
                                      : (r_a >> w_alu_b[4:0]);
         3'b110:  w_alu_y = r_a | w_alu_b;
         default: w_alu_y = r_a & w_alu_b;
      endcase
   end

   always_comb begin
      case (w_opcode)
         OPC_LUI:   w_exec_y = w_imm_u;
         OPC_AUIPC: w_exec_y = r_old_pc + w_imm_u;
         default:   w_exec_y = w_alu_y;
      endcase
   end

   always_comb begin
      case (w_funct3)
         3'b000:  w_branch_taken = (r_a == r_b);
         3'b001:  w_branch_taken = (r_a != r_b);
         3'b100:  w_branch_taken = ($signed(r_a) < $signed(r_b));
         3'b101:  w_branch_taken = ($signed(r_a) >= $signed(r_b));
         3'b110:  w_branch_taken = (r_a < r_b);
         3'b111:  w_branch_taken = (r_a >= r_b);
         default: w_branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_next_state   = S_FETCH;
      bus.memAddress = r_pc;
      bus.memWrite   = 1'b0;
      w_rf_we        = 1'b0;
      w_rf_wdata     = r_alu_out;
      case (r_state)
         S_FETCH: w_next_state = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OPC_LOAD, OPC_STORE:                  w_next_state = S_MEMADR;
               OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: w_next_state = S_EXECUTE;
               OPC_BRANCH:                           w_next_state = S_BRANCH;
               OPC_JAL, OPC_JALR:                    w_next_state = S_JUMP;
               default:                              w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR: w_next_state = (w_opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            bus.memAddress = r_alu_out;
            w_next_state   = S_MEMWB;
         end
         S_MEMWB: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = r_mdr;
         end
         S_MEMWRITE: begin
            // a reset landing on this edge must not let the store reach memory
            bus.memAddress = r_alu_out;
            bus.memWrite   = !reset;
         end
         S_EXECUTE: w_next_state = S_ALUWB;
         S_ALUWB:   w_rf_we = 1'b1;
         S_JUMP: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = r_old_pc + 32'd4;
         end
         default: w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= 32'd0;
         r_ir      <= 32'd0;
         r_old_pc  <= 32'd0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_alu_out <= 32'd0;
         r_mdr     <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            r_rf[i] <= 32'd0;
         end
      end else begin
         if (w_rf_we && (w_rd != 5'd0)) begin
            r_rf[w_rd] <= w_rf_wdata;
         end
         case (r_state)
            S_FETCH: begin
               r_ir     <= bus.memReadData;
               r_old_pc <= r_pc;
               r_pc     <= r_pc + 32'd4;
            end
            S_DECODE: begin
               r_a       <= w_rs1_val;
               r_b       <= w_rs2_val;
               r_alu_out <= r_old_pc + w_imm_b;
            end
            S_MEMADR:  r_alu_out <= r_a + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
            S_MEMREAD: r_mdr <= bus.memReadData;
            S_EXECUTE: r_alu_out <= w_exec_y;
            S_BRANCH: begin
               if (w_branch_taken) begin
                  r_pc <= r_alu_out;
               end
            end
            S_JUMP: begin
               r_pc <= (w_opcode == OPC_JAL) ? (r_old_pc + w_imm_j)
                                             : ((r_a + w_imm_i) & ~32'd1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// tb/tb_rv32i_multicycle_core.sv - directed and random programs checked cycle by cycle
// against an instruction-level model that expands each instruction into its bus trace.
module tb_rv32i_multicycle_core;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst_sampled = 1'b1;
   int   n_vec = 0;
   int   n_fail = 0;

   logic [31:0] mem   [0:1023];
   logic [31:0] m_mem [0:1023];
   logic [31:0] m_rf  [0:31];
   logic [31:0] m_pc;
   exp_t        q[$];

   rv32i_multicycle_core_if bus ();

   rv32i_multicycle_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.memReadData = mem[bus.memAddress[11:2]];

   always @(posedge clk) begin
      if (bus.memWrite) mem[bus.memAddress[11:2]] = bus.memWriteData;
   end

   always @(posedge clk) rst_sampled <= reset;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1, logic [31:0] f3,
                                         logic [31:0] rd, logic [31:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2, logic [31:0] rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                         logic [31:0] f3, logic [31:0] rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] enc_b(logic [31:0] off, logic [31:0] rs2, logic [31:0] rs1,
                                         logic [31:0] f3);
      return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(logic [31:0] off, logic [31:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
   endfunction

   function automatic logic [31:0] enc_u(logic [31:0] imm20, logic [31:0] rd, logic [31:0] op);
      return {imm20[19:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] alu(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic alt);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.we   = w;
      e.wd   = d;
      q.push_back(e);
   endtask

   task automatic model_reset();
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   task automatic wr(input logic [4:0] rd, input logic [31:0] v);
      if (rd != 5'd0) m_rf[rd] = v;
   endtask

   // One architectural instruction; each push is one clock of expected bus activity.
   task automatic model_step();
      logic [31:0] ins, pc4, a, b, ii, is, ib, iu, ij, ea;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        taken;
      ins = m_mem[m_pc[11:2]];
      op  = ins[6:0];
      rd  = ins[11:7];
      f3  = ins[14:12];
      a   = m_rf[ins[19:15]];
      b   = m_rf[ins[24:20]];
      ii  = {{20{ins[31]}}, ins[31:20]};
      is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu  = {ins[31:12], 12'd0};
      ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      pc4 = m_pc + 32'd4;
      push(m_pc, 1'b0, 32'd0);
      case (op)
         7'h37, 7'h17, 7'h13, 7'h33: begin
            for (int k = 0; k < 3; k++) push(pc4, 1'b0, 32'd0);
            if (op == 7'h37)      wr(rd, iu);
            else if (op == 7'h17) wr(rd, m_pc + iu);
            else if (op == 7'h13) wr(rd, alu(a, ii, f3, (f3 == 3'd5) && ins[30]));
            else                  wr(rd, alu(a, b, f3, ins[30]));
            m_pc = pc4;
         end
         7'h03: begin
            ea = a + ii;
            push(pc4, 1'b0, 32'd0);
            push(pc4, 1'b0, 32'd0);
            push(ea, 1'b0, 32'd0);
            push(pc4, 1'b0, 32'd0);
            wr(rd, m_mem[ea[11:2]]);
            m_pc = pc4;
         end
         7'h23: begin
            ea = a + is;
            push(pc4, 1'b0, 32'd0);
            push(pc4, 1'b0, 32'd0);
            push(ea, 1'b1, b);
            m_mem[ea[11:2]] = b;
            m_pc = pc4;
         end
         7'h63: begin
            push(pc4, 1'b0, 32'd0);
            push(pc4, 1'b0, 32'd0);
            case (f3)
               3'd0:    taken = (a == b);
               3'd1:    taken = (a != b);
               3'd4:    taken = ($signed(a) < $signed(b));
               3'd5:    taken = ($signed(a) >= $signed(b));
               3'd6:    taken = (a < b);
               3'd7:    taken = (a >= b);
               default: taken = 1'b0;
            endcase
            m_pc = taken ? m_pc + ib : pc4;
         end
         7'h6f, 7'h67: begin
            push(pc4, 1'b0, 32'd0);
            push(pc4, 1'b0, 32'd0);
            ea = (op == 7'h6f) ? m_pc + ij : (a + ii) & ~32'd1;
            wr(rd, pc4);
            m_pc = ea;
         end
         default: begin
            push(pc4, 1'b0, 32'd0);
            m_pc = pc4;
         end
      endcase
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_sampled) begin
         model_reset();
         q.delete();
         if (reset) begin
            check("reset_addr", bus.memAddress, 32'd0);
            check("reset_we", {31'd0, bus.memWrite}, 32'd0);
            check("reset_wdata", bus.memWriteData, 32'd0);
         end else begin
            model_step();
            e = q.pop_front();
            check("first_fetch_addr", bus.memAddress, e.addr);
            check("first_fetch_we", {31'd0, bus.memWrite}, 32'd0);
            check("first_fetch_wdata", bus.memWriteData, 32'd0);
         end
      end else begin
         if (q.size() == 0) model_step();
         e = q.pop_front();
         check("cycle_addr", bus.memAddress, e.addr);
         check("cycle_we", {31'd0, bus.memWrite}, {31'd0, e.we & ~reset});
         if (e.we && !reset) check("store_data", bus.memWriteData, e.wd);
      end
   end

   task automatic put(input int idx, input logic [31:0] v);
      mem[idx]   = v;
      m_mem[idx] = v;
   endtask

   task automatic begin_phase();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 1024; i++) put(i, 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input string name, input int idx, input logic [31:0] v);
      check(name, mem[idx], v);
      check({name, "_model"}, m_mem[idx], v);
   endtask

   function automatic logic [31:0] gen_instr(int idx);
      int          k, t, f3;
      logic [31:0] imm, f7, w;
      k = $urandom_range(0, 15);
      if (k <= 3) begin
         f3  = $urandom_range(0, 7);
         imm = $urandom;
         if (f3 == 1) imm = imm & 32'h1f;
         if (f3 == 5) imm = (imm & 32'h41f);
         return enc_i(imm, $urandom_range(0, 31), f3, $urandom_range(0, 31), 32'h13);
      end else if (k <= 5) begin
         f3 = $urandom_range(0, 7);
         f7 = (((f3 == 0) || (f3 == 5)) && ($urandom_range(0, 1) == 1)) ? 32'h20 : 32'h0;
         return enc_r(f7, $urandom_range(0, 31), $urandom_range(0, 31), f3, $urandom_range(0, 31));
      end else if (k <= 7) begin
         return enc_u($urandom, $urandom_range(0, 31), (k == 6) ? 32'h37 : 32'h17);
      end else if (k <= 11) begin
         imm = 32'h400 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
         if (k <= 9) return enc_i(imm, 0, 2, $urandom_range(0, 31), 32'h03);
         return enc_s(imm, $urandom_range(0, 31), 0);
      end else if (k <= 14) begin
         t = $urandom_range(0, 254);
         if (t == idx) t = (t + 1) % 255;
         if (k <= 13) begin
            case ($urandom_range(0, 5))
               0: f3 = 0;
               1: f3 = 1;
               2: f3 = 4;
               3: f3 = 5;
               4: f3 = 6;
               default: f3 = 7;
            endcase
            return enc_b((t - idx) * 4, $urandom_range(0, 31), $urandom_range(0, 31), f3);
         end
         if ($urandom_range(0, 1) == 1) return enc_j((t - idx) * 4, $urandom_range(0, 31));
         return enc_i(4 * t + $urandom_range(0, 1), 0, 0, $urandom_range(0, 31), 32'h67);
      end
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[6:0] = 7'h00;
         1: w[6:0] = 7'h7f;
         2: w[6:0] = 7'h0f;
         3: w[6:0] = 7'h73;
         default: w[6:0] = 7'h2b;
      endcase
      return w;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) put(i, 32'd0);

      // ALU sequence then two stores
      begin_phase();
      put(0, 32'h00a58513);
      put(1, enc_i(0, 0, 0, 1, 32'h13));
      put(2, enc_i(1, 0, 0, 2, 32'h13));
      put(3, enc_i(2, 1, 0, 3, 32'h13));
      put(4, enc_s(64, 10, 0));
      put(5, enc_s(68, 3, 0));
      put(6, enc_j(0, 0));
      release_reset();
      run(40);
      check_mem("alu_sw_64", 16, 32'd10);
      check_mem("alu_sw_68", 17, 32'd2);

      // load, increment, store
      begin_phase();
      put(32, 32'h0000_00ff);
      put(0, enc_i(128, 0, 2, 5, 32'h03));
      put(1, enc_i(1, 5, 0, 5, 32'h13));
      put(2, enc_s(132, 5, 0));
      put(3, enc_j(0, 0));
      release_reset();
      run(30);
      check_mem("lw_inc_sw", 33, 32'h100);

      // taken beq skips a store, untaken bne falls through
      begin_phase();
      put(50, 32'hdead);
      put(0, enc_i(7, 0, 0, 2, 32'h13));
      put(1, enc_b(8, 0, 0, 0));
      put(2, enc_s(200, 2, 0));
      put(3, enc_b(8, 0, 0, 1));
      put(4, enc_s(204, 2, 0));
      put(5, enc_j(0, 0));
      release_reset();
      run(40);
      check_mem("beq_skipped_store", 50, 32'hdead);
      check_mem("bne_fallthrough_store", 51, 32'd7);

      // jal link value, jalr to an odd address
      begin_phase();
      put(33, 32'hbeef);
      put(0, enc_j(12, 1));
      put(1, enc_s(132, 0, 0));
      put(2, enc_s(132, 0, 0));
      put(3, enc_s(128, 1, 0));
      put(4, enc_i(29, 0, 0, 1, 32'h13));
      put(5, enc_i(0, 1, 0, 0, 32'h67));
      put(6, enc_s(132, 0, 0));
      put(7, enc_s(136, 1, 0));
      put(8, enc_j(0, 0));
      release_reset();
      run(50);
      check_mem("jal_link", 32, 32'd4);
      check_mem("jalr_skipped", 33, 32'hbeef);
      check_mem("jalr_target", 34, 32'd29);

      // x0 write, signed/unsigned corner values, illegal opcode
      begin_phase();
      put(35, 32'h1234);
      put(0, enc_i(5, 0, 0, 0, 32'h13));
      put(1, enc_s(140, 0, 0));
      put(2, enc_u(32'h80000, 6, 32'h37));
      put(3, enc_i(1, 0, 0, 7, 32'h13));
      put(4, enc_r(32'h20, 6, 0, 0, 8));
      put(5, enc_r(32'h20, 7, 6, 5, 9));
      put(6, enc_r(0, 6, 0, 3, 10));
      put(7, enc_r(0, 0, 6, 2, 11));
      put(8, 32'h0000_0000);
      put(9, enc_r(0, 7, 6, 5, 12));
      put(10, enc_s(144, 8, 0));
      put(11, enc_s(148, 9, 0));
      put(12, enc_s(152, 10, 0));
      put(13, enc_s(156, 11, 0));
      put(14, enc_s(160, 12, 0));
      put(15, enc_j(0, 0));
      release_reset();
      run(90);
      check_mem("x0_stays_zero", 35, 32'd0);
      check_mem("sub_min", 36, 32'h8000_0000);
      check_mem("sra_min", 37, 32'hc000_0000);
      check_mem("sltu_min", 38, 32'd1);
      check_mem("slt_min", 39, 32'd1);
      check_mem("srl_min", 40, 32'h4000_0000);

      // reset lands on the edge that ends MEMREAD of the first lw
      begin_phase();
      put(32, 32'h55);
      put(0, enc_i(128, 0, 2, 5, 32'h03));
      put(1, enc_s(132, 5, 0));
      put(2, enc_j(0, 0));
      release_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check_mem("abort_no_store_yet", 33, 32'd0);
      release_reset();
      run(30);
      check_mem("after_abort_store", 33, 32'h55);

      // random programs confined to the code region, data in 0x400..0x7ff
      for (int p = 0; p < 4; p++) begin
         begin_phase();
         for (int i = 0; i < 255; i++) put(i, gen_instr(i));
         put(255, enc_j(-1020, 0));
         for (int i = 256; i < 512; i++) put(i, $urandom);
         release_reset();
         run(2000);
      end

      begin_phase();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
